// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a registered one-hot grant, a per-owner hold
// limit and a one-cycle turnaround between grants.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic               valid_nxt;
  logic               timeout_nxt;
  logic [N-1:0]       gnt_nxt;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               found;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          idx_nxt   = winner;
          valid_nxt = 1'b1;
          hold_nxt  = CNT_ONE;
        end
      end
      GRANT: begin
        if (rel || !req[gnt_idx] ||
            ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT))) begin
          // Release outranks the hold limit, so the pulse only fires on a forced exit.
          timeout_nxt = !(rel || !req[gnt_idx]);
          state_nxt   = IDLE;
          valid_nxt   = 1'b0;
          ptr_nxt     = gnt_idx + IDX_W'(1);
          hold_nxt    = '0;
        end else if (hold_cnt != '1) begin
          hold_nxt = hold_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        hold_nxt  = '0;
      end
    endcase
    gnt_nxt = valid_nxt ? (N'(1) << idx_nxt) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with MAX_HOLD=4: reset, single grant,
// rotation, wrap fairness, hold timeout and release/timeout priority.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = '0;
  logic       rel = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req   = '0;
    rel   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (!$onehot0(gnt) || (gnt_valid !== |gnt) || (timeout && gnt_valid)) begin
        bad++;
        $display("FAIL invariant gnt=%h valid=%b timeout=%b", gnt, gnt_valid, timeout);
      end
    end
  end

  task automatic test_reset();
    tick();
    tick();
    reset = 1'b0;
    req = 8'h10;
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h10, 3'd4, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_pregrant got=%h/%0d/%b/%b exp=10/4/1/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_async got=%h/%b/%b exp=00/0/0", gnt, gnt_valid, timeout);
    end
    tick();
    reset = 1'b0;
    req = 8'h01;
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_after got=%h/%0d/%b/%b exp=01/0/1/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = '0;
    tick();
  endtask

  task automatic test_single();
    pulse_reset();
    req = 8'h08;
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
      bad++; $display("FAIL single_grant got=%h/%0d/%b/%b exp=08/3/1/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    rel = 1'b1;
    tick();
    total++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL single_release got=%h/%b/%b exp=00/0/0", gnt, gnt_valid, timeout);
    end
    // release held through IDLE must not block the next grant
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
      bad++; $display("FAIL single_rel_idle got=%h/%0d/%b/%b exp=08/3/1/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    tick();
    rel = 1'b0;
    req = '0;
    tick();
  endtask

  task automatic test_rotation();
    logic [7:0] e_gnt;
    logic [2:0] e_idx;
    pulse_reset();
    req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      e_idx = 3'(k % 8);
      e_gnt = 8'(1) << e_idx;
      total++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== {e_gnt, e_idx, 1'b1, 1'b0}) begin
        bad++; $display("FAIL rotation_grant k=%0d got=%h/%0d exp=%h/%0d", k, gnt, gnt_idx, e_gnt, e_idx);
      end
      rel = 1'b1;
      tick();
      total++;
      if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
        bad++; $display("FAIL rotation_gap k=%0d got=%h/%b/%b exp=00/0/0", k, gnt, gnt_valid, timeout);
      end
      rel = 1'b0;
      if (k == 8) req = '0;
      tick();
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    req = 8'h20;
    tick();
    rel = 1'b1;
    req = '0;
    tick();
    rel = 1'b0;
    req = 8'h41;
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h40, 3'd6, 1'b1}) begin
      bad++; $display("FAIL wrap_first got=%h/%0d/%b exp=40/6/1", gnt, gnt_idx, gnt_valid);
    end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      bad++; $display("FAIL wrap_second got=%h/%0d/%b exp=01/0/1", gnt, gnt_idx, gnt_valid);
    end
    rel = 1'b1;
    req = '0;
    tick();
    rel = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    pulse_reset();
    req = 8'h04;
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
        bad++; $display("FAIL timeout_hold c=%0d got=%h/%0d/%b/%b exp=04/2/1/0", c, gnt, gnt_idx, gnt_valid, timeout);
      end
    end
    tick();
    total++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL timeout_pulse got=%h/%b/%b exp=00/0/1", gnt, gnt_valid, timeout);
    end
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
      bad++; $display("FAIL timeout_regrant got=%h/%0d/%b/%b exp=04/2/1/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    // requester 0 joins; owner 2 keeps requesting and must yield after its timeout
    req = 8'h05;
    tick();
    tick();
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      bad++; $display("FAIL timeout_hold2 got=%h/%0d/%b exp=04/2/1", gnt, gnt_idx, gnt_valid);
    end
    tick();
    total++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b1}) begin
      bad++; $display("FAIL timeout_pulse2 got=%h/%b/%b exp=00/0/1", gnt, gnt_valid, timeout);
    end
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL timeout_fair got=%h/%0d/%b/%b exp=01/0/1/0", gnt, gnt_idx, gnt_valid, timeout);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    req = 8'h04;
    tick();
    tick();
    tick();
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      bad++; $display("FAIL simul_fourth got=%h/%0d/%b exp=04/2/1", gnt, gnt_idx, gnt_valid);
    end
    rel = 1'b1;
    tick();
    total++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL simul_release_wins got=%h/%b/%b exp=00/0/0", gnt, gnt_valid, timeout);
    end
    rel = 1'b0;
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      bad++; $display("FAIL simul_regrant got=%h/%0d/%b exp=04/2/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h05;
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      bad++; $display("FAIL simul_nonowner got=%h/%0d/%b exp=04/2/1", gnt, gnt_idx, gnt_valid);
    end
    req = 8'h01;
    tick();
    total++;
    if ({gnt, gnt_valid, timeout} !== {8'h00, 1'b0, 1'b0}) begin
      bad++; $display("FAIL simul_owner_drop got=%h/%b/%b exp=00/0/0", gnt, gnt_valid, timeout);
    end
    tick();
    total++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      bad++; $display("FAIL simul_next got=%h/%0d/%b exp=01/0/1", gnt, gnt_idx, gnt_valid);
    end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
